// File: rtl/furv_pkg.sv
// furv_pkg: shared types for the furv memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT)
//   arb_owner_t : which port owns the in-flight transaction
//   mem_cmd_t   : memory command fields muxed from the winning port
//   FETCH_WSTRB : byte enables driven for instruction fetches
//   sat_inc4    : saturating increment used by the anti-starvation counter
package furv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_cmd_t;

  localparam logic [3:0] FETCH_WSTRB = 4'b1111;

  // Increment v, but never past lim.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/furv_arb_timer.sv
// furv_arb_timer: response timeout counter for the memory arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : reload the count with 0 (transaction accepted)
//   i_en       : count this cycle (arbiter waiting for a response)
//   o_expire   : counting and the count has reached LIMIT-1
// LIMIT == 0 disables expiry entirely.
module furv_arb_timer
  import furv_pkg::*;
#(
  parameter int unsigned LIMIT = 64,
  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] r_cnt;

  // Saturates at LAST so a disabled/stalled timer never wraps back to a
  // value that could fire a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && (r_cnt != LAST)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = (LIMIT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/furv_mem_arb.sv
// furv_mem_arb: shares one single-ported memory bus between the furv
// instruction-fetch port and load/store data port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   if_req/if_addr      : fetch request (held until if_gnt)
//   if_gnt              : fetch accepted (combinational)
//   if_rvalid/rdata/err : registered one-cycle fetch response
//   d_req/we/addr/wdata/wstrb : data request (held until d_gnt)
//   d_gnt               : data accepted (combinational)
//   d_rvalid/rdata/err  : registered one-cycle data response (loads and stores)
//   m_req/we/addr/wdata/wstrb, m_gnt : memory request handshake
//   m_rvalid/m_rdata    : memory response
//   busy                : a transaction is in flight
// One transaction outstanding at a time; data beats fetch unless fetch has
// been passed over STARVE_LIMIT times in a row. A silent memory is answered
// with an error after TIMEOUT_CYCLES cycles (0 = wait forever).
module furv_mem_arb
  import furv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory bus
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  // status
  output logic        busy
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t r_state, w_state_nxt;
  arb_owner_t r_owner, w_owner_nxt;
  logic       r_owner_st, w_owner_st_nxt;  // owner is a store: no read data
  logic [3:0] r_starve;

  logic       w_any_req;
  logic       w_fetch_win;
  logic       w_accept;
  logic       w_done;     // memory answered this cycle
  logic       w_tmo;      // timer expired with no answer
  logic       w_expire;
  mem_cmd_t   w_cmd;

  // ---------------- winner selection and command mux ----------------
  assign w_any_req   = if_req | d_req;
  assign w_fetch_win = if_req && (!d_req || (r_starve >= STARVE_MAX));

  always_comb begin
    if (w_fetch_win) begin
      w_cmd.we    = 1'b0;
      w_cmd.addr  = if_addr;
      w_cmd.wdata = '0;
      w_cmd.wstrb = FETCH_WSTRB;
    end else begin
      w_cmd.we    = d_we;
      w_cmd.addr  = d_addr;
      w_cmd.wdata = d_wdata;
      w_cmd.wstrb = d_wstrb;
    end
  end

  assign m_we    = w_cmd.we;
  assign m_addr  = w_cmd.addr;
  assign m_wdata = w_cmd.wdata;
  assign m_wstrb = w_cmd.wstrb;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= NONE;
      r_owner_st <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_st <= w_owner_st_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_owner_st_nxt = r_owner_st;
    w_accept       = 1'b0;
    w_done         = 1'b0;
    w_tmo          = 1'b0;
    m_req          = 1'b0;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    busy           = 1'b0;
    case (r_state)
      IDLE: begin
        m_req  = w_any_req;
        if_gnt = w_fetch_win & m_gnt;
        d_gnt  = !w_fetch_win & d_req & m_gnt;
        if (w_any_req && m_gnt) begin
          w_accept       = 1'b1;
          w_state_nxt    = WAIT;
          w_owner_nxt    = w_fetch_win ? FETCH : DATA;
          w_owner_st_nxt = !w_fetch_win & d_we;
        end
      end
      WAIT: begin
        busy = 1'b1;
        // A response arriving on the expiry cycle still counts as success.
        if (m_rvalid)      w_done = 1'b1;
        else if (w_expire) w_tmo  = 1'b1;
        if (m_rvalid || w_expire) begin
          w_state_nxt    = IDLE;
          w_owner_nxt    = NONE;
          w_owner_st_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_owner_nxt = NONE;
      end
    endcase
  end

  // ---------------- anti-starvation counter ----------------
  // Counts data wins that left a fetch waiting; any other accept clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve <= '0;
    else if (w_accept) begin
      if (!w_fetch_win && if_req) r_starve <= sat_inc4(r_starve, STARVE_MAX);
      else                        r_starve <= '0;
    end
  end

  // ---------------- timeout ----------------
  furv_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_accept),
    .i_en     (r_state == WAIT),
    .o_expire (w_expire)
  );

  // ---------------- response registers ----------------
  // rdata holds between pulses; err is only ever high alongside rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      if (w_done || w_tmo) begin
        if (r_owner == FETCH) begin
          if_rvalid <= 1'b1;
          if_rdata  <= w_tmo ? 32'd0 : m_rdata;
          if_err    <= w_tmo;
        end else if (r_owner == DATA) begin
          d_rvalid  <= 1'b1;
          d_rdata   <= (w_tmo || r_owner_st) ? 32'd0 : m_rdata;
          d_err     <= w_tmo;
        end
      end
    end
  end

endmodule

// File: tb/tb_furv_mem_arb.sv
// Self-checking bench for furv_mem_arb (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
// Inputs change 1ns after posedge; combinational outputs are sampled 2ns
// after posedge, registered outputs 1ns after posedge. Every response the
// memory model is told to produce is pushed to a scoreboard queue and
// popped by a monitor when the DUT pulses if_rvalid/d_rvalid.
module tb_furv_mem_arb;
  import furv_pkg::*;

  localparam int unsigned STARVE = 4;
  localparam int unsigned TMO    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_wstrb = '0;
  logic        m_req, m_we, m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata = '0;
  logic [3:0]  m_wstrb;
  logic        busy;

  furv_mem_arb #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];

  always @(posedge clk) begin : monitor
    rsp_t e;
    #1;
    if (rst_n && (if_rvalid || d_rvalid)) begin
      if (sb.size() == 0) begin
        check("stray_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_owner", {30'd0, d_rvalid, if_rvalid}, e.is_d ? 32'd2 : 32'd1);
        if (e.is_d) begin
          check("rsp_d_rdata", d_rdata, e.rdata);
          check("rsp_d_err", {31'd0, d_err}, {31'd0, e.err});
        end else begin
          check("rsp_if_rdata", if_rdata, e.rdata);
          check("rsp_if_err", {31'd0, if_err}, {31'd0, e.err});
        end
      end
    end
  end

  // ---------------- combinational vector table ----------------
  typedef struct {
    logic        ireq, dreq, dwe, mgnt;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dwstrb;
    logic [31:0] mrdata;
    logic        e_ignt, e_dgnt, e_mreq, e_mwe;
    logic [31:0] e_maddr;
    logic [3:0]  e_mwstrb;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic exp_f;

    //            ireq dreq dwe mgnt iaddr        daddr        dwdata        wstrb  mrdata        ig dg mr mwe maddr        mwstrb
    vecs[0] = '{1'b0,1'b0,1'b0,1'b1, 32'h0,       32'h0,       32'h0,        4'h0, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,     4'hF};
    vecs[1] = '{1'b1,1'b0,1'b0,1'b0, 32'h10,      32'h0,       32'h0,        4'h0, 32'h0,        1'b0,1'b0,1'b1,1'b0, 32'h10,    4'hF};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0, 32'h0,       32'h20,      32'h0,        4'h5, 32'h0,        1'b0,1'b0,1'b1,1'b0, 32'h20,    4'h5};
    vecs[3] = '{1'b0,1'b1,1'b1,1'b0, 32'h0,       32'h24,      32'h1111,     4'hC, 32'h0,        1'b0,1'b0,1'b1,1'b1, 32'h24,    4'hC};
    vecs[4] = '{1'b1,1'b1,1'b1,1'b0, 32'h30,      32'h34,      32'h2222,     4'h3, 32'h0,        1'b0,1'b0,1'b1,1'b1, 32'h34,    4'h3};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b1, 32'h40,      32'h0,       32'h0,        4'h0, 32'h00000013, 1'b1,1'b0,1'b1,1'b0, 32'h40,    4'hF};
    vecs[6] = '{1'b0,1'b1,1'b0,1'b1, 32'h0,       32'h80,      32'h0,        4'hF, 32'hA5A50001, 1'b0,1'b1,1'b1,1'b0, 32'h80,    4'hF};
    vecs[7] = '{1'b0,1'b1,1'b1,1'b1, 32'h0,       32'h84,      32'h55,       4'h1, 32'hFFFFFFFF, 1'b0,1'b1,1'b1,1'b1, 32'h84,    4'h1};
    vecs[8] = '{1'b1,1'b1,1'b0,1'b1, 32'h90,      32'h94,      32'h0,        4'h6, 32'h0BADF00D, 1'b0,1'b1,1'b1,1'b0, 32'h94,    4'h6};
    vecs[9] = '{1'b1,1'b0,1'b0,1'b1, 32'h98,      32'h0,       32'h0,        4'h0, 32'h12345678, 1'b1,1'b0,1'b1,1'b0, 32'h98,    4'hF};

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
    check("rst_d_gnt",     {31'd0, d_gnt},     32'd0);
    check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst_d_rvalid",  {31'd0, d_rvalid},  32'd0);
    check("rst_if_err",    {31'd0, if_err},    32'd0);
    check("rst_d_err",     {31'd0, d_err},     32'd0);
    check("rst_if_rdata",  if_rdata,           32'd0);
    check("rst_d_rdata",   d_rdata,            32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_m_req",     {31'd0, m_req},     32'd0);
    rst_n = 1'b1;

    // ---------------- reset mid-WAIT ----------------
    tick();
    if_req = 1'b1; if_addr = 32'h700; m_gnt = 1'b1;
    #1 check("rmw_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0; m_gnt = 1'b0;
    check("rmw_busy_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 check("rmw_busy_async", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h99;
    tick();
    m_rvalid = 1'b0;
    check("rmw_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rmw_d_rvalid",  {31'd0, d_rvalid},  32'd0);
    check("rmw_busy",      {31'd0, busy},      32'd0);
    tick();
    check("rmw_if_rvalid2", {31'd0, if_rvalid}, 32'd0);

    // ---------------- vector table ----------------
    // starve count stays below the limit throughout, so data always wins here.
    for (int i = 0; i < NV; i++) begin
      if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
      d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].daddr;
      d_wdata = vecs[i].dwdata; d_wstrb = vecs[i].dwstrb; m_gnt = vecs[i].mgnt;
      #1;
      check($sformatf("v%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, vecs[i].e_ignt});
      check($sformatf("v%0d_d_gnt", i),  {31'd0, d_gnt},  {31'd0, vecs[i].e_dgnt});
      check($sformatf("v%0d_m_req", i),  {31'd0, m_req},  {31'd0, vecs[i].e_mreq});
      if (vecs[i].ireq || vecs[i].dreq) begin
        check($sformatf("v%0d_m_addr", i),  m_addr, vecs[i].e_maddr);
        check($sformatf("v%0d_m_we", i),    {31'd0, m_we}, {31'd0, vecs[i].e_mwe});
        check($sformatf("v%0d_m_wstrb", i), {28'd0, m_wstrb}, {28'd0, vecs[i].e_mwstrb});
      end
      if (vecs[i].dreq)
        check($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].dwdata);
      if (vecs[i].e_ignt || vecs[i].e_dgnt) begin
        tick();
        if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
        m_rvalid = 1'b1; m_rdata = vecs[i].mrdata;
        sb.push_back('{vecs[i].e_dgnt,
                       (vecs[i].e_dgnt && vecs[i].dwe) ? 32'd0 : vecs[i].mrdata, 1'b0});
        tick();
        m_rvalid = 1'b0;
        tick();
      end else begin
        tick();
        if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
        tick();
      end
    end

    // ---------------- single fetch ----------------
    if_req = 1'b1; if_addr = 32'h100; m_gnt = 1'b1;
    #1;
    check("sf_if_gnt",  {31'd0, if_gnt},   32'd1);
    check("sf_m_addr",  m_addr,            32'h100);
    check("sf_m_wstrb", {28'd0, m_wstrb},  32'hF);
    check("sf_m_we",    {31'd0, m_we},     32'd0);
    tick();
    if_req = 1'b0; m_gnt = 1'b0;
    check("sf_busy",     {31'd0, busy},  32'd1);
    check("sf_m_req_wt", {31'd0, m_req}, 32'd0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h00500093;
    sb.push_back('{1'b0, 32'h00500093, 1'b0});
    check("sf_no_early_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick();
    m_rvalid = 1'b0;
    check("sf_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("sf_if_rdata",  if_rdata,           32'h00500093);
    check("sf_if_err",    {31'd0, if_err},    32'd0);
    tick();
    check("sf_pulse_end", {31'd0, if_rvalid}, 32'd0);
    check("sf_rdata_hold", if_rdata,          32'h00500093);

    // ---------------- simultaneous requests ----------------
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'h3;
    m_gnt = 1'b1;
    #1;
    check("sim_d_gnt",   {31'd0, d_gnt},  32'd1);
    check("sim_if_gnt",  {31'd0, if_gnt}, 32'd0);
    check("sim_m_wstrb", {28'd0, m_wstrb}, 32'h3);
    check("sim_m_wdata", m_wdata,         32'hDEADBEEF);
    tick();
    d_req = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h12345678;
    sb.push_back('{1'b1, 32'd0, 1'b0});
    tick();
    m_rvalid = 1'b0;
    // response pulse and the next grant share this cycle
    #1;
    check("sim_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("sim_d_rdata",  d_rdata,           32'd0);
    check("sim_if_gnt2",  {31'd0, if_gnt},   32'd1);
    check("sim_m_addr2",  m_addr,            32'h300);
    tick();
    if_req = 1'b0; m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hCAFE0001;
    sb.push_back('{1'b0, 32'hCAFE0001, 1'b0});
    tick();
    m_rvalid = 1'b0;
    tick();

    // ---------------- starvation ----------------
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_wstrb = 4'hF; m_gnt = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      exp_f = (g == 4);
      check($sformatf("stv%0d_if_gnt", g), {31'd0, if_gnt}, {31'd0, exp_f});
      check($sformatf("stv%0d_d_gnt", g),  {31'd0, d_gnt},  {31'd0, !exp_f});
      tick();
      if (exp_f) if_req = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'h100 + g;
      sb.push_back('{!exp_f, 32'h100 + g, 1'b0});
      tick();
      m_rvalid = 1'b0;
    end
    m_gnt = 1'b0;
    if_req = 1'b1;
    #1 check("stv_cnt_cleared_m_addr", m_addr, 32'h800);
    tick();
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // ---------------- timeout ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; m_gnt = 1'b1;
    #1 check("tmo_d_gnt", {31'd0, d_gnt}, 32'd1);
    sb.push_back('{1'b1, 32'd0, 1'b1});
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin d_req = 1'b0; m_gnt = 1'b0; end
      check($sformatf("tmo_early%0d", k), {31'd0, d_rvalid}, 32'd0);
    end
    tick();
    check("tmo_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("tmo_d_err",    {31'd0, d_err},    32'd1);
    check("tmo_d_rdata",  d_rdata,           32'd0);
    check("tmo_busy",     {31'd0, busy},     32'd0);
    m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    tick();
    m_rvalid = 1'b0;
    check("late_d_rvalid",  {31'd0, d_rvalid},  32'd0);
    check("late_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("late_d_rdata",   d_rdata,            32'd0);
    tick();

    // ---------------- m_rvalid on the expiry cycle ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5100; m_gnt = 1'b1;
    #1 check("race_d_gnt", {31'd0, d_gnt}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin d_req = 1'b0; m_gnt = 1'b0; end
    end
    m_rvalid = 1'b1; m_rdata = 32'h77;
    sb.push_back('{1'b1, 32'h77, 1'b0});
    tick();
    m_rvalid = 1'b0;
    check("race_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("race_d_err",    {31'd0, d_err},    32'd0);
    check("race_d_rdata",  d_rdata,           32'h77);
    tick();

    // ---------------- m_gnt held low ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6000; d_wdata = 32'h11; d_wstrb = 4'hF;
    m_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("mg%0d_d_gnt", k),  {31'd0, d_gnt}, 32'd0);
      check($sformatf("mg%0d_m_req", k),  {31'd0, m_req}, 32'd1);
      check($sformatf("mg%0d_m_addr", k), m_addr,         32'h6000);
      tick();
    end
    m_gnt = 1'b1;
    #1 check("mg_d_gnt_rise", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0; m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h4444;
    sb.push_back('{1'b1, 32'd0, 1'b0});
    tick();
    m_rvalid = 1'b0;
    tick();
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
